// File: rtl/arcade_input_ctrl.sv
// Input conditioning between hps_io and the game core: PS/2 key state, joystick
// merge with opposing-direction resolution, and a shaped, debounced coin pulse.
module arcade_input_ctrl #(
  parameter int COIN_PULSE_CYC   = 400000,
  parameter int COIN_HOLDOFF_CYC = 4000000,
  parameter bit SOCD_NEUTRAL     = 1'b1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  output logic        p1_up,
  output logic        p1_down,
  output logic        p1_left,
  output logic        p1_right,
  output logic        p1_fire,
  output logic        p2_up,
  output logic        p2_down,
  output logic        p2_left,
  output logic        p2_right,
  output logic        p2_fire,
  output logic        start1,
  output logic        start2,
  output logic        coin,
  output logic [7:0]  coin_count
);

  localparam int CNT_MAX = (COIN_PULSE_CYC > COIN_HOLDOFF_CYC) ? COIN_PULSE_CYC : COIN_HOLDOFF_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(COIN_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(COIN_HOLDOFF_CYC - 1);

  // Keys that share a function are held separately so releasing one keeps the other.
  typedef struct packed {
    logic p1_up, p1_down, p1_left, p1_right, p1_fire_space, p1_fire_ctrl;
    logic start1_f1, start1_one, start2_f2, start2_two, coin_five, coin_six;
    logic p2_up, p2_down, p2_left, p2_right, p2_fire;
  } key_state_t;

  typedef enum logic [1:0] {IDLE, PULSE, HOLD, WAIT_REL} coin_state_t;

  key_state_t  r_keys;
  logic        r_toggle;
  logic [8:0]  w_code;
  logic        w_event;

  assign w_code  = ps2_key[8:0];
  assign w_event = (ps2_key[10] != r_toggle);

  always_ff @(posedge clk_sys) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      r_keys   <= '0;
      r_toggle <= ps2_key[10];
    end else if (w_event) begin
      r_toggle <= ps2_key[10];
      case (w_code)
        9'h175: r_keys.p1_up         <= ps2_key[9];
        9'h172: r_keys.p1_down       <= ps2_key[9];
        9'h16B: r_keys.p1_left       <= ps2_key[9];
        9'h174: r_keys.p1_right      <= ps2_key[9];
        9'h029: r_keys.p1_fire_space <= ps2_key[9];
        9'h014: r_keys.p1_fire_ctrl  <= ps2_key[9];
        9'h005: r_keys.start1_f1     <= ps2_key[9];
        9'h016: r_keys.start1_one    <= ps2_key[9];
        9'h006: r_keys.start2_f2     <= ps2_key[9];
        9'h01E: r_keys.start2_two    <= ps2_key[9];
        9'h02E: r_keys.coin_five     <= ps2_key[9];
        9'h036: r_keys.coin_six      <= ps2_key[9];
        9'h02D: r_keys.p2_up         <= ps2_key[9];
        9'h02B: r_keys.p2_down       <= ps2_key[9];
        9'h023: r_keys.p2_left       <= ps2_key[9];
        9'h034: r_keys.p2_right      <= ps2_key[9];
        9'h01C: r_keys.p2_fire       <= ps2_key[9];
        default: ;
      endcase
    end
  end

  logic w_p1_u, w_p1_d, w_p1_l, w_p1_r, w_p2_u, w_p2_d, w_p2_l, w_p2_r;
  logic w_p1_ud, w_p1_lr, w_p2_ud, w_p2_lr;

  assign w_p1_u = r_keys.p1_up    | joystick_0[3];
  assign w_p1_d = r_keys.p1_down  | joystick_0[2];
  assign w_p1_l = r_keys.p1_left  | joystick_0[1];
  assign w_p1_r = r_keys.p1_right | joystick_0[0];
  assign w_p2_u = r_keys.p2_up    | joystick_1[3];
  assign w_p2_d = r_keys.p2_down  | joystick_1[2];
  assign w_p2_l = r_keys.p2_left  | joystick_1[1];
  assign w_p2_r = r_keys.p2_right | joystick_1[0];

  assign w_p1_ud = SOCD_NEUTRAL && w_p1_u && w_p1_d;
  assign w_p1_lr = SOCD_NEUTRAL && w_p1_l && w_p1_r;
  assign w_p2_ud = SOCD_NEUTRAL && w_p2_u && w_p2_d;
  assign w_p2_lr = SOCD_NEUTRAL && w_p2_l && w_p2_r;

  logic r_p1_up, r_p1_down, r_p1_left, r_p1_right, r_p1_fire;
  logic r_p2_up, r_p2_down, r_p2_left, r_p2_right, r_p2_fire;
  logic r_start1, r_start2;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      {r_p1_up, r_p1_down, r_p1_left, r_p1_right, r_p1_fire} <= '0;
      {r_p2_up, r_p2_down, r_p2_left, r_p2_right, r_p2_fire} <= '0;
      {r_start1, r_start2} <= '0;
    end else begin
      r_p1_up    <= w_p1_u & ~w_p1_ud;
      r_p1_down  <= w_p1_d & ~w_p1_ud;
      r_p1_left  <= w_p1_l & ~w_p1_lr;
      r_p1_right <= w_p1_r & ~w_p1_lr;
      r_p1_fire  <= r_keys.p1_fire_space | r_keys.p1_fire_ctrl | joystick_0[4];
      r_p2_up    <= w_p2_u & ~w_p2_ud;
      r_p2_down  <= w_p2_d & ~w_p2_ud;
      r_p2_left  <= w_p2_l & ~w_p2_lr;
      r_p2_right <= w_p2_r & ~w_p2_lr;
      r_p2_fire  <= r_keys.p2_fire | joystick_1[4];
      r_start1   <= r_keys.start1_f1 | r_keys.start1_one | joystick_0[5] | joystick_1[5];
      r_start2   <= r_keys.start2_f2 | r_keys.start2_two | joystick_0[6] | joystick_1[6];
    end
  end

  // Coin shaping: one fixed-width pulse per press, then a dead time, then wait for release.
  coin_state_t      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]       r_coin_count, w_coin_count_nxt;
  logic             r_coin, w_coin_nxt, w_coin_raw;

  assign w_coin_raw = r_keys.coin_five | r_keys.coin_six | joystick_0[7] | joystick_1[7];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves a signal unassigned (which would infer a latch).
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_coin_count_nxt = r_coin_count;
    case (r_state)
      IDLE: if (w_coin_raw) begin
        w_state_nxt      = PULSE;
        w_cnt_nxt        = PULSE_LOAD;
        w_coin_count_nxt = r_coin_count + 8'd1;
      end
      PULSE: if (r_cnt == '0) begin
        w_state_nxt = HOLD;
        w_cnt_nxt   = HOLD_LOAD;
      end else begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
      end
      HOLD: if (r_cnt == '0) w_state_nxt = WAIT_REL;
            else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      WAIT_REL: if (!w_coin_raw) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    w_coin_nxt = (w_state_nxt == PULSE);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_coin       <= 1'b0;
      r_coin_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_coin       <= w_coin_nxt;
      r_coin_count <= w_coin_count_nxt;
    end
  end

  assign p1_up      = r_p1_up;
  assign p1_down    = r_p1_down;
  assign p1_left    = r_p1_left;
  assign p1_right   = r_p1_right;
  assign p1_fire    = r_p1_fire;
  assign p2_up      = r_p2_up;
  assign p2_down    = r_p2_down;
  assign p2_left    = r_p2_left;
  assign p2_right   = r_p2_right;
  assign p2_fire    = r_p2_fire;
  assign start1     = r_start1;
  assign start2     = r_start2;
  assign coin       = r_coin;
  assign coin_count = r_coin_count;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Directed bench for arcade_input_ctrl: key decode, joystick merge/SOCD, and
// coin pulse shaping with short pulse/holdoff parameters.
module tb_arcade_input_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0, joystick_1;
  logic p1_up, p1_down, p1_left, p1_right, p1_fire;
  logic p2_up, p2_down, p2_left, p2_right, p2_fire;
  logic start1, start2, coin;
  logic [7:0] coin_count;

  arcade_input_ctrl #(
    .COIN_PULSE_CYC(4), .COIN_HOLDOFF_CYC(8), .SOCD_NEUTRAL(1'b1)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key),
    .joystick_0(joystick_0), .joystick_1(joystick_1),
    .p1_up(p1_up), .p1_down(p1_down), .p1_left(p1_left), .p1_right(p1_right), .p1_fire(p1_fire),
    .p2_up(p2_up), .p2_down(p2_down), .p2_left(p2_left), .p2_right(p2_right), .p2_fire(p2_fire),
    .start1(start1), .start2(start2), .coin(coin), .coin_count(coin_count)
  );

  always #5 clk_sys = ~clk_sys;

  // {p1 U D L R F, p2 U D L R F, start1, start2, coin}
  logic [12:0] w_outs;
  assign w_outs = {p1_up, p1_down, p1_left, p1_right, p1_fire,
                   p2_up, p2_down, p2_left, p2_right, p2_fire, start1, start2, coin};

  int   vectors = 0;
  int   miscompares = 0;
  logic tgl;
  int   high_cyc, rises;
  logic prev_coin;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic send_key(input logic pressed, input logic [8:0] code);
    tgl     = ~tgl;
    ps2_key = {tgl, pressed, code};
  endtask

  task automatic clear_window();
    high_cyc  = 0;
    rises     = 0;
    prev_coin = 1'b0;
  endtask

  task automatic coin_window(input int n);
    repeat (n) begin
      @(negedge clk_sys);
      if (coin) high_cyc++;
      if (coin && !prev_coin) rises++;
      prev_coin = coin;
    end
  endtask

  initial begin
    // Reset with an already-set toggle and a pressed 0x175 code: no event may follow.
    tgl        = 1'b1;
    ps2_key    = {1'b1, 1'b1, 9'h175};
    joystick_0 = '0;
    joystick_1 = '0;
    reset      = 1'b1;
    step(3);
    reset = 1'b0;
    step(10);
    check("reset_outs", 16'(w_outs), 16'h0000);
    check("reset_count", 16'(coin_count), 16'h0000);

    // PS/2 key decode and latency
    send_key(1'b1, 9'h175);
    step(1);
    check("p1_up_latency", 16'(w_outs), 16'h0000);
    step(1);
    check("p1_up_press", 16'(w_outs), 16'h1000);
    step(5);
    check("p1_up_held", 16'(w_outs), 16'h1000);
    send_key(1'b0, 9'h175);
    step(2);
    check("p1_up_release", 16'(w_outs), 16'h0000);
    send_key(1'b1, 9'h075);
    step(2);
    check("nonext_075", 16'(w_outs), 16'h0000);

    send_key(1'b1, 9'h029);
    step(2);
    check("fire_space", 16'(w_outs), 16'h0100);
    send_key(1'b1, 9'h014);
    step(2);
    check("fire_both", 16'(w_outs), 16'h0100);
    send_key(1'b0, 9'h029);
    step(2);
    check("fire_ctrl_held", 16'(w_outs), 16'h0100);
    send_key(1'b0, 9'h014);
    step(2);
    check("fire_none", 16'(w_outs), 16'h0000);

    send_key(1'b1, 9'h02D);
    step(2);
    check("p2_up_key", 16'(w_outs), 16'h0080);
    send_key(1'b1, 9'h02B);
    step(2);
    check("p2_socd_keys", 16'(w_outs), 16'h0000);
    send_key(1'b0, 9'h02D);
    step(2);
    check("p2_down_key", 16'(w_outs), 16'h0040);
    send_key(1'b0, 9'h02B);
    step(2);
    check("p2_keys_off", 16'(w_outs), 16'h0000);

    send_key(1'b1, 9'h016);
    step(2);
    check("start1_key", 16'(w_outs), 16'h0004);
    send_key(1'b0, 9'h016);
    step(2);
    check("start1_key_off", 16'(w_outs), 16'h0000);

    // Joystick merge and SOCD (one register stage)
    joystick_0 = 16'h000C;
    step(1);
    check("p1_socd_ud", 16'(w_outs), 16'h0000);
    joystick_0 = 16'h0008;
    step(1);
    check("p1_joy_up", 16'(w_outs), 16'h1000);
    joystick_0 = 16'h0003;
    step(1);
    check("p1_socd_lr", 16'(w_outs), 16'h0000);
    joystick_0 = 16'h0010;
    step(1);
    check("p1_joy_fire", 16'(w_outs), 16'h0100);
    joystick_0 = 16'h0000;
    joystick_1 = 16'h0040;
    step(1);
    check("start2_joy1", 16'(w_outs), 16'h0002);
    joystick_1 = 16'h0024;
    step(1);
    check("p2_down_start1", 16'(w_outs), 16'h0044);
    joystick_1 = 16'h0000;
    step(2);

    // Held coin: one 4-cycle pulse
    clear_window();
    joystick_0 = 16'h0080;
    coin_window(50);
    check("held_high_cyc", 16'(high_cyc), 16'd4);
    check("held_pulses", 16'(rises), 16'd1);
    check("held_count", 16'(coin_count), 16'd1);
    joystick_0 = 16'h0000;
    step(2);

    clear_window();
    joystick_0 = 16'h0080;
    coin_window(20);
    joystick_0 = 16'h0000;
    check("second_high_cyc", 16'(high_cyc), 16'd4);
    check("second_pulses", 16'(rises), 16'd1);
    check("second_count", 16'(coin_count), 16'd2);
    step(2);

    // Re-press during holdoff is ignored
    clear_window();
    joystick_0 = 16'h0080;
    coin_window(6);
    joystick_0 = 16'h0000;
    coin_window(2);
    joystick_0 = 16'h0080;
    coin_window(2);
    joystick_0 = 16'h0000;
    coin_window(20);
    check("holdoff_pulses", 16'(rises), 16'd1);
    check("holdoff_high_cyc", 16'(high_cyc), 16'd4);
    check("holdoff_count", 16'(coin_count), 16'd3);

    // Coin from keyboard '5'
    clear_window();
    send_key(1'b1, 9'h02E);
    coin_window(20);
    check("key5_pulses", 16'(rises), 16'd1);
    check("key5_count", 16'(coin_count), 16'd4);
    send_key(1'b0, 9'h02E);
    step(3);

    // Preload to 255 then wrap
    for (int i = 0; i < 251; i++) begin
      joystick_0 = 16'h0080;
      step(14);
      joystick_0 = 16'h0000;
      step(2);
    end
    check("count_255", 16'(coin_count), 16'd255);
    joystick_0 = 16'h0080;
    step(2);
    check("count_wrap", 16'(coin_count), 16'd0);
    check("wrap_coin_high", 16'(coin), 16'd1);

    // Reset mid-pulse, then re-arm with coin still held
    reset = 1'b1;
    step(1);
    check("rst_mid_coin", 16'(coin), 16'd0);
    check("rst_mid_count", 16'(coin_count), 16'd0);
    reset = 1'b0;
    step(1);
    check("rearm_coin", 16'(coin), 16'd1);
    check("rearm_count", 16'(coin_count), 16'd1);
    joystick_0 = 16'h0000;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
